// File: rtl/hyperbus_dev_responder.sv
// rtl/hyperbus_dev_responder.sv - HyperBus device-side responder: CA decode, latency, SRAM bursts, ID register space
// One bus CK period per ck_en_i cycle; all outputs are registered.
module hyperbus_dev_responder #(
  parameter int unsigned AddrWidth  = 16,
  parameter int unsigned LatCycles  = 6,
  parameter bit          AddLatency = 1'b0,
  parameter int unsigned WrapWords  = 16,
  parameter logic [15:0] IdReg0     = 16'h0C81
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_ni,
  input  logic                 ck_en_i,
  input  logic [15:0]          dq_i,
  input  logic [1:0]           rwds_i,
  output logic [15:0]          dq_o,
  output logic                 dq_oe_o,
  output logic                 rwds_o,
  output logic                 rwds_oe_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [15:0]          mem_wdata_o,
  output logic [1:0]           mem_be_o,
  input  logic [15:0]          mem_rdata_i,
  output logic                 error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LAT, S_WRITE, S_READ, S_REGREAD
  } state_t;

  localparam int unsigned         LatTotal = AddLatency ? 2 * LatCycles : LatCycles;
  localparam logic [7:0]          LatLast  = 8'(LatTotal - 1);
  localparam logic [AddrWidth-1:0] WrapMask = AddrWidth'(WrapWords - 1);
  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);

  state_t               state, state_n;
  logic                 beat, ca_done;
  logic [1:0]           ca_cnt;
  logic [31:0]          ca_hi;
  logic [7:0]           lat_cnt;
  logic [AddrWidth-1:0] addr, addr_next;
  logic                 is_read, is_reg, is_linear;
  logic [15:0]          fifo_mem [2];
  logic                 fifo_wp, fifo_rp;
  logic [1:0]           fifo_cnt, occ_next;
  logic                 rd_inflight, rd_pend, pf_active, issue, push, pop;

  assign beat      = ck_en_i & ~cs_ni;
  assign addr_next = is_linear ? addr + AddrOne
                               : ((addr & ~WrapMask) | ((addr + AddrOne) & WrapMask));

  // Credits: buffered words plus the read whose data lands next cycle never exceed two.
  assign rd_pend   = mem_req_o & ~mem_we_o;
  assign push      = rd_inflight;
  assign pop       = (state == S_READ) && beat && (fifo_cnt != 2'd0);
  assign occ_next  = fifo_cnt + {1'b0, push} - {1'b0, pop};
  assign pf_active = ((state == S_LAT) || (state == S_READ)) && is_read && !is_reg && !cs_ni;
  assign issue     = pf_active && (({1'b0, occ_next} + {2'b00, rd_pend}) < 3'd2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    ca_done = 1'b0;
    case (state)
      S_IDLE: if (!cs_ni) state_n = S_CA;
      S_CA: begin
        if (beat && (ca_cnt == 2'd2)) begin
          ca_done = 1'b1;
          // Register-space writes carry no latency.
          state_n = (!ca_hi[31] && ca_hi[30]) ? S_WRITE : S_LAT;
        end
      end
      S_LAT: begin
        if (beat && (lat_cnt == LatLast))
          state_n = !is_read ? S_WRITE : (is_reg ? S_REGREAD : S_READ);
      end
      S_WRITE, S_READ, S_REGREAD: state_n = state;
      default: state_n = S_IDLE;
    endcase
    if (cs_ni) state_n = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ca_cnt      <= 2'd0;
      ca_hi       <= 32'd0;
      lat_cnt     <= 8'd0;
      addr        <= '0;
      is_read     <= 1'b0;
      is_reg      <= 1'b0;
      is_linear   <= 1'b0;
      fifo_mem[0] <= 16'h0000;
      fifo_mem[1] <= 16'h0000;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
      rd_inflight <= 1'b0;
      dq_o        <= 16'h0000;
      dq_oe_o     <= 1'b0;
      rwds_o      <= 1'b0;
      rwds_oe_o   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 16'h0000;
      mem_be_o    <= 2'b00;
      error_o     <= 1'b0;
    end else begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      error_o   <= 1'b0;
      if (cs_ni) begin
        // Deselect drops any word still returning from the SRAM.
        fifo_cnt    <= 2'd0;
        fifo_wp     <= 1'b0;
        fifo_rp     <= 1'b0;
        rd_inflight <= 1'b0;
        dq_oe_o     <= 1'b0;
        rwds_oe_o   <= 1'b0;
        rwds_o      <= 1'b0;
        ca_cnt      <= 2'd0;
        lat_cnt     <= 8'd0;
      end else begin
        rd_inflight <= rd_pend;
        if (push) begin
          fifo_mem[fifo_wp] <= mem_rdata_i;
          fifo_wp           <= ~fifo_wp;
        end
        if (pop) fifo_rp <= ~fifo_rp;
        fifo_cnt <= occ_next;
        case (state)
          S_IDLE: begin
            ca_cnt    <= 2'd0;
            lat_cnt   <= 8'd0;
            rwds_oe_o <= 1'b1;
            rwds_o    <= AddLatency;
          end
          S_CA: begin
            if (beat) begin
              ca_cnt <= ca_cnt + 2'd1;
              if (ca_cnt == 2'd0) ca_hi[31:16] <= dq_i;
              if (ca_cnt == 2'd1) ca_hi[15:0]  <= dq_i;
              if (ca_done) begin
                is_read   <= ca_hi[31];
                is_reg    <= ca_hi[30];
                is_linear <= ca_hi[29];
                addr      <= AddrWidth'({ca_hi[28:0], dq_i[2:0]});
                lat_cnt   <= 8'd0;
                rwds_oe_o <= 1'b0;
                rwds_o    <= 1'b0;
              end
            end
          end
          S_LAT: if (beat) lat_cnt <= lat_cnt + 8'd1;
          S_WRITE: begin
            if (beat) begin
              addr <= addr_next;
              if (!is_reg && (rwds_i != 2'b11)) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_addr_o  <= addr;
                mem_wdata_o <= dq_i;
                mem_be_o    <= ~rwds_i;
              end
            end
          end
          S_READ, S_REGREAD: begin
            if (beat) begin
              dq_oe_o   <= 1'b1;
              rwds_oe_o <= 1'b1;
              rwds_o    <= ~rwds_o;
              if (state == S_REGREAD) begin
                dq_o <= (addr == '0) ? IdReg0 : 16'h0000;
                addr <= addr_next;
              end else if (pop) begin
                dq_o <= fifo_mem[fifo_rp];
              end else begin
                dq_o    <= 16'h0000;
                error_o <= 1'b1;
              end
            end
          end
          default: ;
        endcase
        if (issue) begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= addr;
          addr       <= addr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_dev_responder.sv
// tb/tb_hyperbus_dev_responder.sv - directed self-checking bench for hyperbus_dev_responder
// Runs with doubled latency (AddLatency=1, LatCycles=6) against a behavioural SRAM.
module tb_hyperbus_dev_responder;
  logic        clk = 1'b0, rst = 1'b1, cs_n = 1'b1, ck_en = 1'b0;
  logic [15:0] dq_in = 16'h0000;
  logic [1:0]  rwds_in = 2'b00;
  logic [15:0] dq_out, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        dq_oe, rwds_out, rwds_oe, mem_req, mem_we, error;
  logic [1:0]  mem_be;
  logic [1:0]  ca_rwds;
  logic [15:0] sram [0:65535];
  int          n_checks = 0, n_fail = 0, n_wr = 0, n_rd = 0, base;

  always #5 clk = ~clk;

  hyperbus_dev_responder #(.AddrWidth(16), .LatCycles(6), .AddLatency(1'b1),
                           .WrapWords(16), .IdReg0(16'h0C81)) dut (
    .clk_i(clk), .rst_i(rst), .cs_ni(cs_n), .ck_en_i(ck_en), .dq_i(dq_in),
    .rwds_i(rwds_in), .dq_o(dq_out), .dq_oe_o(dq_oe), .rwds_o(rwds_out),
    .rwds_oe_o(rwds_oe), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rdata_i(mem_rdata), .error_o(error));

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        n_wr++;
        if (mem_be[1]) sram[mem_addr][15:8] = mem_wdata[15:8];
        if (mem_be[0]) sram[mem_addr][7:0]  = mem_wdata[7:0];
      end else begin
        n_rd++;
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic [1:0] m);
    dq_in = d; rwds_in = m; ck_en = 1'b1; tick();
    ck_en = 1'b0; rwds_in = 2'b00; tick();
  endtask

  task automatic start(input logic rd, input logic sp, input logic lin, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, sp, lin, a[31:3], 13'd0, a[2:0]};
    cs_n = 1'b0; tick();
    ca_rwds = {rwds_oe, rwds_out};
    beat(ca[47:32], 2'b00); beat(ca[31:16], 2'b00); beat(ca[15:0], 2'b00);
  endtask

  task automatic latency(); for (int i = 0; i < 12; i++) beat(16'h0000, 2'b00); endtask
  task automatic stop(); cs_n = 1'b1; tick(); tick(); endtask

  task automatic rd_beat(input string tag, input logic [15:0] exp);
    ck_en = 1'b1; tick(); chk(tag, dq_out, exp);
    ck_en = 1'b0; tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;
    sram[16'h000E] = 16'hE0E0; sram[16'h000F] = 16'hF0F0;
    sram[16'h0000] = 16'h0A0A; sram[16'h0001] = 16'h0B0B;
    tick(); tick();
    chk("reset_outputs", {dq_out, dq_oe, rwds_out, rwds_oe, mem_req, mem_we, error}, 32'd0);
    rst = 1'b0; tick();

    // Linear write of four words at 0x10
    start(1'b0, 1'b0, 1'b1, 32'h10);
    chk("ca_rwds_addlat", ca_rwds, 2'b11);
    chk("lat_rwds_oe", rwds_oe, 1'b0);
    latency();
    dq_in = 16'h1111; ck_en = 1'b1; tick();
    chk("wr_req", {mem_req, mem_we, mem_be}, 4'b1111);
    chk("wr_addr_data", {mem_addr, mem_wdata}, 32'h0010_1111);
    ck_en = 1'b0; tick();
    beat(16'h2222, 2'b00); beat(16'h3333, 2'b00); beat(16'h4444, 2'b00);
    stop();
    chk("wr_count", n_wr, 4);
    for (int i = 0; i < 4; i++) chk("wr_lin_mem", sram[16 + i], 16'h1111 * (i + 1));

    // Linear read back
    start(1'b1, 1'b0, 1'b1, 32'h10);
    latency();
    rd_beat("rd_lin0", 16'h1111);
    chk("rd_oe_strobe", {dq_oe, rwds_oe, rwds_out}, 3'b111);
    rd_beat("rd_lin1", 16'h2222);
    chk("rd_strobe_toggle", rwds_out, 1'b0);
    rd_beat("rd_lin2", 16'h3333);
    rd_beat("rd_lin3", 16'h4444);
    cs_n = 1'b1; tick();
    chk("rd_end_oe", {dq_oe, rwds_oe}, 2'b00);
    tick();

    // Byte-masked write, fully masked beat skips an address
    start(1'b0, 1'b0, 1'b1, 32'h20);
    latency();
    dq_in = 16'hABCD; rwds_in = 2'b01; ck_en = 1'b1; tick();
    chk("mask_be", mem_be, 2'b10);
    ck_en = 1'b0; rwds_in = 2'b00; tick();
    beat(16'h5555, 2'b11); beat(16'h7777, 2'b00);
    stop();
    chk("mask_mem20", sram[16'h20], 16'hAB00);
    chk("mask_mem21", sram[16'h21], 16'h0000);
    chk("mask_mem22", sram[16'h22], 16'h7777);
    chk("mask_count", n_wr, 6);

    // Wrapped read crossing the 16-word boundary
    start(1'b1, 1'b0, 1'b0, 32'h0E);
    latency();
    rd_beat("wrap0", 16'hE0E0);
    rd_beat("wrap1", 16'hF0F0);
    rd_beat("wrap2", 16'h0A0A);
    rd_beat("wrap3", 16'h0B0B);
    stop();

    // Register-space read and write
    base = n_rd;
    start(1'b1, 1'b1, 1'b1, 32'h0);
    latency();
    rd_beat("reg_id0", 16'h0C81);
    rd_beat("reg_word1", 16'h0000);
    stop();
    chk("reg_rd_no_sram", n_rd - base, 0);
    base = n_wr;
    start(1'b0, 1'b1, 1'b1, 32'h5);
    dq_in = 16'h9999; ck_en = 1'b1; tick();
    chk("reg_wr_no_req", mem_req, 1'b0);
    ck_en = 1'b0; tick();
    stop();
    chk("reg_wr_no_sram", n_wr - base, 0);

    // Continuous beats outrun the two-word prefetch
    start(1'b1, 1'b0, 1'b1, 32'h10);
    latency();
    ck_en = 1'b1; tick();
    chk("burst_b0", {error, dq_out}, {1'b0, 16'h1111});
    tick();
    chk("burst_b1", {error, dq_out}, {1'b0, 16'h2222});
    tick();
    chk("burst_underrun", {error, dq_out}, {1'b1, 16'h0000});
    ck_en = 1'b0; tick();
    stop();

    // Deselect after the second write beat; coincident beat is ignored
    base = n_wr;
    start(1'b0, 1'b0, 1'b1, 32'h30);
    latency();
    beat(16'hA1A1, 2'b00); beat(16'hA2A2, 2'b00);
    cs_n = 1'b1; dq_in = 16'hA3A3; ck_en = 1'b1; tick();
    ck_en = 1'b0; tick();
    chk("abort_wr_count", n_wr - base, 2);
    chk("abort_mem32", sram[16'h32], 16'h0000);
    chk("abort_oe", {dq_oe, rwds_oe, mem_req}, 3'b000);

    // Reset in the middle of a read, then a fresh read sees no stale data
    start(1'b1, 1'b0, 1'b1, 32'h10);
    latency();
    rd_beat("pre_rst", 16'h1111);
    rst = 1'b1; tick();
    chk("rst_mid_outputs", {dq_oe, rwds_oe, mem_req, rwds_out}, 4'b0000);
    rst = 1'b0; cs_n = 1'b1; tick();
    start(1'b1, 1'b0, 1'b1, 32'h12);
    latency();
    rd_beat("post_rst0", 16'h3333);
    rd_beat("post_rst1", 16'h4444);
    stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
